mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter_rr_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter slice.
//   word_t      : 32-bit data/address word
//   ramstate_t  : RAM status reported back on ramstate
//   arb_state_t : arbiter FSM state (ARB / XFER), legacy-compatible constants
//   req_id_t    : requester identity {core, is_dcache}
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ARB  = 1'b0;
  localparam arb_state_t XFER = 1'b1;

  // Core index width; the arbiter supports one or two cores.
  localparam int CORE_W = 1;

  typedef struct packed {
    logic [CORE_W-1:0] core;
    logic              is_dcache;
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and RAM-side signals around the arbiter.
//   slave  : the arbiter (takes cache requests and RAM status, drives
//            waits/loads and the RAM strobes)
//   master : the cache controllers plus RAM model
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) ();

  logic [CPUS-1:0]    iREN;
  logic [CPUS*32-1:0] iaddr;
  logic [CPUS-1:0]    dREN;
  logic [CPUS-1:0]    dWEN;
  logic [CPUS*32-1:0] daddr;
  logic [CPUS*32-1:0] dstore;
  logic [CPUS-1:0]    iwait;
  logic [CPUS-1:0]    dwait;
  logic [CPUS*32-1:0] iload;
  logic [CPUS*32-1:0] dload;
  logic               ramREN;
  logic               ramWEN;
  word_t              ramaddr;
  word_t              ramstore;
  word_t              ramload;
  ramstate_t          ramstate;
  logic               arb_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
           arb_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
           arb_err
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin priority encoder.
//   req   : request vector, one bit per core
//   ptr   : index with highest priority this round
//   valid : any request present
//   idx   : first requesting index at or after ptr (wrapping)
module rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] idx
);

  int c;

  // Scan from the farthest offset down so the nearest one to ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % N;
      if (req[c]) begin
        valid = 1'b1;
        idx   = PTR_W'(c);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the icache and dcache of each core.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave -- per-core iREN/iaddr, dREN/dWEN/
//              daddr/dstore in; iwait/dwait/iload/dload out; RAM strobes,
//              address and store data out; ramload/ramstate in; arb_err out
// Dcache requests beat icache requests; within a class the grant rotates.
// A dcache grant is held for BLK_BEATS ACCESS beats so a block moves whole.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS      = 2,
  parameter int BLK_BEATS = 2
) (
  input logic CLK,
  input logic RST,
  mem_arbiter_if.slave bus
);

  localparam int PTR_W  = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int BEAT_W = $clog2(BLK_BEATS) + 1;

  arb_state_t        state;
  req_id_t           grant;
  logic [BEAT_W-1:0] beat;
  logic [PTR_W-1:0]  rr_ptr;
  logic              arb_err_q;

  logic [CPUS-1:0]   dreq;
  logic              d_any, i_any;
  logic [PTR_W-1:0]  d_idx, i_idx;
  logic [PTR_W-1:0]  next_ptr;

  int                gi;
  word_t             g_addr, g_store;
  logic              g_ren, g_wen, g_live;

  assign dreq = bus.dREN | bus.dWEN;

  rr_pick #(.N(CPUS), .PTR_W(PTR_W)) u_pick_d (
    .req   (dreq),
    .ptr   (rr_ptr),
    .valid (d_any),
    .idx   (d_idx)
  );

  rr_pick #(.N(CPUS), .PTR_W(PTR_W)) u_pick_i (
    .req   (bus.iREN),
    .ptr   (rr_ptr),
    .valid (i_any),
    .idx   (i_idx)
  );

  // Granted requester's live request; dWEN wins over dREN when both are set.
  always_comb begin
    gi      = int'(grant.core);
    g_addr  = grant.is_dcache ? bus.daddr[gi*32 +: 32] : bus.iaddr[gi*32 +: 32];
    g_store = bus.dstore[gi*32 +: 32];
    g_wen   = grant.is_dcache & bus.dWEN[gi];
    g_ren   = grant.is_dcache ? (bus.dREN[gi] & ~bus.dWEN[gi]) : bus.iREN[gi];
    g_live  = g_ren | g_wen;
  end

  assign next_ptr = (int'(grant.core) == CPUS - 1) ? '0
                                                   : PTR_W'(int'(grant.core) + 1);

  // RAM strobes and completions are combinational from the grant; RST masks
  // them so an aborted transfer never reports completion.
  always_comb begin
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (!RST && state == XFER && g_live) begin
      bus.ramREN   = g_ren;
      bus.ramWEN   = g_wen;
      bus.ramaddr  = g_addr;
      bus.ramstore = g_store;
      if (bus.ramstate == ACCESS) begin
        if (grant.is_dcache) begin
          bus.dwait[gi] = 1'b0;
          if (g_ren) bus.dload[gi*32 +: 32] = bus.ramload;
        end else begin
          bus.iwait[gi]           = 1'b0;
          bus.iload[gi*32 +: 32]  = bus.ramload;
        end
      end
    end
  end

  assign bus.arb_err = arb_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ARB;
      grant     <= '0;
      beat      <= '0;
      rr_ptr    <= '0;
      arb_err_q <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (d_any) begin
            grant.core      <= CORE_W'(d_idx);
            grant.is_dcache <= 1'b1;
            beat            <= '0;
            state           <= XFER;
          end else if (i_any) begin
            grant.core      <= CORE_W'(i_idx);
            grant.is_dcache <= 1'b0;
            beat            <= '0;
            state           <= XFER;
          end
        end
        XFER: begin
          if (!g_live) begin
            beat   <= '0;
            rr_ptr <= next_ptr;
            state  <= ARB;
          end else if (bus.ramstate == ACCESS) begin
            beat <= beat + BEAT_W'(1);
            if (!(grant.is_dcache && (int'(beat) + 1 < BLK_BEATS))) begin
              rr_ptr <= next_ptr;
              state  <= ARB;
            end
          end else if (bus.ramstate == ERROR) begin
            // Pointer left alone so the failed requester retries first.
            arb_err_q <= 1'b1;
            beat      <= '0;
            state     <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of expected RAM beats.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic RST;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    logic        is_d;
    int          core;
    logic [31:0] addr;
    logic [31:0] store;
    logic        wen;
  } exp_t;

  exp_t sb[$];

  mem_arbiter_if #(.CPUS(2)) bus ();

  mem_arbiter #(.CPUS(2), .BLK_BEATS(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic push(input logic is_d, input int core, input logic [31:0] addr,
                      input logic [31:0] store, input logic wen);
    exp_t e;
    e.is_d = is_d; e.core = core; e.addr = addr; e.store = store; e.wen = wen;
    sb.push_back(e);
  endtask

  // Arbiter must be idle: no strobes, every wait high.
  task automatic check_idle(input string tag);
    #1;
    check({tag, "_iwait"}, 32'(bus.iwait), 32'h3);
    check({tag, "_dwait"}, 32'(bus.dwait), 32'h3);
    check({tag, "_strobe"}, 32'({bus.ramREN, bus.ramWEN}), 32'h0);
  endtask

  // Present ACCESS this cycle and compare the completing beat to the scoreboard.
  task automatic access_beat(input string tag, input logic [31:0] load_val);
    exp_t        e;
    logic        w;
    logic [31:0] ld;
    bus.ramstate = ACCESS;
    bus.ramload  = load_val;
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e  = sb.pop_front();
      w  = e.is_d ? bus.dwait[e.core] : bus.iwait[e.core];
      ld = e.is_d ? bus.dload[e.core*32 +: 32] : bus.iload[e.core*32 +: 32];
      check({tag, "_wait"}, 32'(w), 32'h0);
      check({tag, "_one_low"}, 32'($countones(~{bus.iwait, bus.dwait})), 32'd1);
      check({tag, "_addr"}, bus.ramaddr, e.addr);
      check({tag, "_ren_wen"}, 32'({bus.ramREN, bus.ramWEN}), e.wen ? 32'h1 : 32'h2);
      if (e.wen) check({tag, "_store"}, bus.ramstore, e.store);
      else       check({tag, "_load"}, ld, load_val);
    end
  endtask

  initial begin
    bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    check_idle("reset");
    check("reset_addr", bus.ramaddr, 32'h0);
    check("reset_store", bus.ramstore, 32'h0);
    check("reset_iload", bus.iload[31:0] | bus.iload[63:32], 32'h0);
    check("reset_dload", bus.dload[31:0] | bus.dload[63:32], 32'h0);
    check("reset_err", 32'(bus.arb_err), 32'h0);

    // Single icache read: ARB cycle then one ACCESS cycle.
    tick(); bus.iREN = 2'b01; bus.iaddr[31:0] = 32'h40; push(0, 0, 32'h40, 0, 0);
    check_idle("t1_arb");
    tick(); access_beat("t1", 32'hDEADBEEF);
    tick(); bus.iREN = 2'b00; bus.ramstate = FREE;
    check_idle("t1_after");

    // Dcache write beats a simultaneous icache read; block of two beats.
    tick();
    bus.iREN = 2'b01; bus.iaddr[31:0] = 32'h100;
    bus.dWEN = 2'b10; bus.daddr[63:32] = 32'h200; bus.dstore[63:32] = 32'hCAFE0001;
    push(1, 1, 32'h200, 32'hCAFE0001, 1);
    push(1, 1, 32'h204, 32'hCAFE0002, 1);
    push(0, 0, 32'h100, 0, 0);
    bus.ramstate = FREE;
    check_idle("t2_arb");
    tick(); access_beat("t2_b0", 32'h0);
    tick(); bus.daddr[63:32] = 32'h204; bus.dstore[63:32] = 32'hCAFE0002;
    access_beat("t2_b1", 32'h0);
    tick(); bus.dWEN = 2'b00; bus.ramstate = FREE;
    check_idle("t2_arb2");
    tick(); access_beat("t2_i", 32'h12345678);
    tick(); bus.iREN = 2'b00; bus.ramstate = FREE;
    check_idle("t2_after");

    // Block lock: core1 arrives mid-block and must wait for both beats.
    tick(); bus.dREN = 2'b01; bus.daddr[31:0] = 32'h80; bus.ramstate = FREE;
    push(1, 0, 32'h80, 0, 0); push(1, 0, 32'h84, 0, 0);
    push(1, 1, 32'h300, 0, 0); push(1, 1, 32'h304, 0, 0);
    check_idle("t3_arb");
    tick(); bus.dREN = 2'b11; bus.daddr[63:32] = 32'h300;
    access_beat("t3_c0b0", 32'h11111111);
    tick(); bus.daddr[31:0] = 32'h84; access_beat("t3_c0b1", 32'h22222222);
    tick(); bus.dREN = 2'b10; bus.ramstate = FREE;
    check_idle("t3_arb2");
    tick(); access_beat("t3_c1b0", 32'h33333333);
    tick(); bus.daddr[63:32] = 32'h304; access_beat("t3_c1b1", 32'h44444444);
    tick(); bus.dREN = 2'b00; bus.ramstate = FREE;
    check_idle("t3_after");

    // Round-robin: both cores hold dREN for 8 blocks, grants alternate.
    bus.daddr = {32'hB000, 32'hA000};
    for (int k = 0; k < 8; k++) begin
      tick(); bus.dREN = 2'b11; bus.ramstate = FREE;
      check_idle("t4_arb");
      for (int b = 0; b < 2; b++) begin
        tick();
        push(1, k % 2, (k % 2) ? 32'hB000 : 32'hA000, 0, 0);
        access_beat("t4_beat", 32'(k * 16 + b));
      end
    end
    tick(); bus.dREN = 2'b00; bus.ramstate = FREE;
    check_idle("t4_after");

    // BUSY x3 then ERROR; same requester (core0) retried ahead of core1.
    tick(); bus.iREN = 2'b11; bus.iaddr = {32'h600, 32'h500};
    check_idle("t5_arb");
    for (int n = 0; n < 3; n++) begin
      tick(); bus.ramstate = BUSY; #1;
      check("t5_busy_iwait", 32'(bus.iwait), 32'h3);
      check("t5_busy_ren", 32'(bus.ramREN), 32'h1);
      check("t5_busy_addr", bus.ramaddr, 32'h500);
    end
    tick(); bus.ramstate = ERROR; #1;
    check("t5_err_iwait", 32'(bus.iwait), 32'h3);
    tick(); bus.ramstate = FREE;
    check_idle("t5_retry_arb");
    check("t5_err_flag", 32'(bus.arb_err), 32'h1);
    tick(); push(0, 0, 32'h500, 0, 0); access_beat("t5_retry", 32'h55555555);
    tick(); bus.iREN = 2'b10; bus.ramstate = FREE;
    check_idle("t5_arb2");
    tick(); push(0, 1, 32'h600, 0, 0); access_beat("t5_c1", 32'h66666666);
    tick(); bus.iREN = 2'b00; bus.ramstate = FREE;
    check_idle("t5_after");
    check("t5_err_sticky", 32'(bus.arb_err), 32'h1);

    // Granted request dropped during XFER: no strobe, no completion.
    tick(); bus.iREN = 2'b01; bus.iaddr[31:0] = 32'h700;
    check_idle("t6_arb");
    tick(); bus.iREN = 2'b00; bus.ramstate = ACCESS;
    check_idle("t6_drop");
    tick(); bus.ramstate = FREE;
    check_idle("t6_after");

    // Reset while a write is on the RAM port.
    tick(); bus.dWEN = 2'b01; bus.daddr[31:0] = 32'h800; bus.dstore[31:0] = 32'h77;
    check_idle("t7_arb");
    tick(); bus.ramstate = BUSY; #1;
    check("t7_wen", 32'(bus.ramWEN), 32'h1);
    tick(); RST = 1'b1; bus.ramstate = ACCESS; #1;
    check("t7_rst_dwait", 32'(bus.dwait), 32'h3);
    tick(); RST = 1'b0;
    check_idle("t7_after_rst");
    check("t7_err_clear", 32'(bus.arb_err), 32'h0);
    tick(); bus.dWEN = 2'b00; bus.ramstate = FREE;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
